// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-stage program counter with sequential advance, absolute
//            jump, relative branch and call/return through a circular
//            return-address stack. Sticky error flags for the control unit.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter int               STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             clr_n,
    input  logic                             en,
    input  logic                             jmp,
    input  logic                             br,
    input  logic                             call,
    input  logic                             ret,
    input  logic [WIDTH-1:0]                 target,
    input  logic [WIDTH-1:0]                 offset,
    input  logic                             flag_clr,
    output logic [WIDTH-1:0]                 pc,
    output logic [WIDTH-1:0]                 pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
    output logic                             ras_ovf,
    output logic                             ras_unf,
    output logic                             align_err
);

    localparam int               c_CW        = $clog2(RAS_DEPTH + 1);
    localparam int               c_PW        = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] c_STEP      = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_MASK      = WIDTH'(STEP - 1);
    localparam logic [c_CW-1:0]  c_FULL      = c_CW'(RAS_DEPTH);
    localparam logic [c_PW-1:0]  c_LAST_SLOT = c_PW'(RAS_DEPTH - 1);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [c_PW-1:0]  r_sp;          // next slot to write; top of stack is r_sp-1
    logic [c_CW-1:0]  r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_aln;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_dest;
    logic [WIDTH-1:0] w_next;
    logic [c_PW-1:0]  w_sp_inc;
    logic [c_PW-1:0]  w_sp_dec;
    logic             w_chk;
    logic             w_push;
    logic             w_pop;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_set_aln;

    // Circular pointer arithmetic; depth need not be a power of two.
    assign w_sp_inc = (r_sp == c_LAST_SLOT) ? '0 : r_sp + c_PW'(1);
    assign w_sp_dec = (r_sp == '0) ? c_LAST_SLOT : r_sp - c_PW'(1);
    assign w_seq    = r_pc + c_STEP;
    assign w_top    = r_ras[w_sp_dec];

    // Command decode in priority order ret > call > jmp > br > sequential.
    always_comb begin
        w_dest    = w_seq;
        w_chk     = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (ret) begin
            if (r_cnt != '0) begin
                w_pop  = 1'b1;
                w_dest = w_top;
            end else begin
                w_set_unf = 1'b1;
            end
        end else if (call) begin
            w_push    = 1'b1;
            w_set_ovf = (r_cnt == c_FULL);
            w_dest    = target;
            w_chk     = 1'b1;
        end else if (jmp) begin
            w_dest = target;
            w_chk  = 1'b1;
        end else if (br) begin
            w_dest = r_pc + offset;
            w_chk  = 1'b1;
        end
        // Returned addresses were pushed as pc+STEP and are already aligned.
        w_set_aln = w_chk & (|(w_dest & c_MASK));
        w_next    = w_chk ? (w_dest & ~c_MASK) : w_dest;
    end

    // PC, stack pointer and occupancy advance only on enabled edges.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pc  <= RESET_ADDR;
            r_sp  <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_pc <= w_next;
            if (w_push) begin
                r_sp <= w_sp_inc;
                if (r_cnt != c_FULL) begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end else if (w_pop) begin
                r_sp  <= w_sp_dec;
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

    // Stack storage; when full the write slot holds the oldest entry.
    always_ff @(posedge clk) begin
        if (clr_n && en && w_push) begin
            r_ras[r_sp] <= w_seq;
        end
    end

    // Sticky flags: enabled set beats flag_clr, which works regardless of en.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_aln <= 1'b0;
        end else begin
            r_ovf <= (en & w_set_ovf) | (r_ovf & ~flag_clr);
            r_unf <= (en & w_set_unf) | (r_unf & ~flag_clr);
            r_aln <= (en & w_set_aln) | (r_aln & ~flag_clr);
        end
    end

    assign pc        = r_pc;
    assign pc_next   = w_next;
    assign ras_cnt   = r_cnt;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
    assign align_err = r_aln;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer: directed scenarios plus
//            randomized commands against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RADDR = 32'h100;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        en, jmp, br, call, ret, flag_clr;
    logic [31:0] target, offset;
    logic [31:0] pc, pc_next;
    logic [2:0]  ras_cnt;
    logic        ras_ovf, ras_unf, align_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_ovf, m_unf, m_aln;

    pc_sequencer #(
        .WIDTH(WIDTH), .STEP(4), .RESET_ADDR(RADDR), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .jmp(jmp), .br(br), .call(call),
        .ret(ret), .target(target), .offset(offset), .flag_clr(flag_clr),
        .pc(pc), .pc_next(pc_next), .ras_cnt(ras_cnt), .ras_ovf(ras_ovf),
        .ras_unf(ras_unf), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = RADDR;
        m_stk.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_aln = 1'b0;
    endtask

    function automatic logic [31:0] model_next();
        logic [31:0] d;
        if (ret)              d = (m_stk.size() > 0) ? m_stk[$] : m_pc + 32'd4;
        else if (call || jmp) d = target - (target % 32'd4);
        else if (br) begin
            d = m_pc + offset;
            d = d - (d % 32'd4);
        end
        else                  d = m_pc + 32'd4;
        return d;
    endfunction

    task automatic model_edge();
        logic [31:0] nx, bd;
        logic        mis;
        nx  = model_next();
        mis = 1'b0;
        if (flag_clr) begin m_ovf = 1'b0; m_unf = 1'b0; m_aln = 1'b0; end
        if (en) begin
            if (ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1'b1;
            end else if (call) begin
                if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); m_ovf = 1'b1; end
                m_stk.push_back(m_pc + 32'd4);
                mis = (target % 32'd4) != 0;
            end else if (jmp) begin
                mis = (target % 32'd4) != 0;
            end else if (br) begin
                bd  = m_pc + offset;
                mis = (bd % 32'd4) != 0;
            end
            if (mis) m_aln = 1'b1;
            m_pc = nx;
        end
    endtask

    task automatic drive(input bit e, input bit r, input bit c, input bit j, input bit b,
                         input logic [31:0] t, input logic [31:0] o, input bit fc);
        en = e; ret = r; call = c; jmp = j; br = b; target = t; offset = o; flag_clr = fc;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
        n_cmp++; if (ras_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", ras_cnt); end
        n_cmp++; if ({ras_ovf, ras_unf, align_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {ras_ovf, ras_unf, align_err}); end
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== 32'h100 + 32'(4 * (i + 1))) begin n_err++; $display("FAIL seq_after_reset got %h exp %h", pc, 32'h100 + 32'(4 * (i + 1))); end
        end
        drive(1, 0, 1, 0, 0, 32'h400, 0, 0);
        step();
        n_cmp++; if (ras_cnt !== 3'd1) begin n_err++; $display("FAIL pre_async_cnt got %0d exp 1", ras_cnt); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2 clr_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL async_reset_pc got %h exp 100", pc); end
        n_cmp++; if (ras_cnt !== 3'd0) begin n_err++; $display("FAIL async_reset_cnt got %0d exp 0", ras_cnt); end
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
        step();
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jmp_top got %h exp fffffffc", pc); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pc_next !== 32'h0) begin n_err++; $display("FAIL wrap_pc_next got %h exp 0", pc_next); end
        step();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 0", pc); end
        n_cmp++; if ({ras_ovf, ras_unf, align_err} !== 3'b000) begin n_err++; $display("FAIL wrap_flags got %b exp 000", {ras_ovf, ras_unf, align_err}); end
        drive(1, 0, 0, 1, 0, 32'h20, 0, 0);
        step();
        drive(1, 0, 0, 0, 1, 0, 32'hFFFF_FFF0, 0);
        step();
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL br_negative got %h exp 10", pc); end
    endtask

    task automatic test_call_ret();
        drive(1, 0, 1, 0, 0, 32'h400, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h400 || ras_cnt !== 3'd1) begin n_err++; $display("FAIL call pc %h cnt %0d exp 400/1", pc, ras_cnt); end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h14 || ras_cnt !== 3'd0) begin n_err++; $display("FAIL ret pc %h cnt %0d exp 14/0", pc, ras_cnt); end
        drive(1, 0, 0, 1, 0, 32'h10, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 32'h400, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pc_next !== 32'h14) begin n_err++; $display("FAIL stall_pc_next got %h exp 14", pc_next); end
        step();
        step();
        n_cmp++; if (pc !== 32'h400 || ras_cnt !== 3'd1) begin n_err++; $display("FAIL stall_hold pc %h cnt %0d exp 400/1", pc, ras_cnt); end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h14 || ras_cnt !== 3'd0) begin n_err++; $display("FAIL ret_after_stall pc %h cnt %0d exp 14/0", pc, ras_cnt); end
    endtask

    task automatic test_overflow();
        drive(1, 0, 0, 1, 0, 32'h0, 0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_cmp++; if (ras_ovf !== 1'b0 || ras_cnt !== 3'd4) begin n_err++; $display("FAIL full_no_ovf ovf %b cnt %0d exp 0/4", ras_ovf, ras_cnt); end
            end
            drive(1, 0, 1, 0, 0, 32'((i + 1) * 32'h100), 0, 0);
            step();
        end
        n_cmp++; if (ras_ovf !== 1'b1 || ras_cnt !== 3'd4) begin n_err++; $display("FAIL ovf ovf %b cnt %0d exp 1/4", ras_ovf, ras_cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            step();
            n_cmp++; if (pc !== 32'h404 - 32'(i * 32'h100)) begin n_err++; $display("FAIL ovf_ret got %h exp %h", pc, 32'h404 - 32'(i * 32'h100)); end
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h108 || ras_unf !== 1'b1 || ras_cnt !== 3'd0) begin n_err++; $display("FAIL unf pc %h unf %b cnt %0d exp 108/1/0", pc, ras_unf, ras_cnt); end
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        n_cmp++; if ({ras_ovf, ras_unf, align_err} !== 3'b000) begin n_err++; $display("FAIL flag_clr got %b exp 000", {ras_ovf, ras_unf, align_err}); end
        drive(1, 0, 0, 1, 0, 32'h50, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 32'h60, 0, 0);
        step();
        drive(1, 1, 1, 1, 0, 32'h300, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h54 || ras_cnt !== 3'd0) begin n_err++; $display("FAIL ret_priority pc %h cnt %0d exp 54/0", pc, ras_cnt); end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h58 || ras_unf !== 1'b1) begin n_err++; $display("FAIL no_push pc %h unf %b exp 58/1", pc, ras_unf); end
        drive(1, 0, 0, 1, 1, 32'h500, 32'h40, 0);
        step();
        n_cmp++; if (pc !== 32'h500) begin n_err++; $display("FAIL jmp_over_br got %h exp 500", pc); end
    endtask

    task automatic test_align();
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 0, 0, 1, 0, 32'h203, 0, 0);
        step();
        n_cmp++; if (pc !== 32'h200 || align_err !== 1'b1) begin n_err++; $display("FAIL misalign pc %h aln %b exp 200/1", pc, align_err); end
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        n_cmp++; if (align_err !== 1'b0) begin n_err++; $display("FAIL aln_clear got %b exp 0", align_err); end
        drive(1, 0, 0, 1, 0, 32'h307, 0, 1);
        step();
        n_cmp++; if (pc !== 32'h304 || align_err !== 1'b1) begin n_err++; $display("FAIL set_wins pc %h aln %b exp 304/1", pc, align_err); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        n_cmp++; if (pc !== 32'h304 || align_err !== 1'b0) begin n_err++; $display("FAIL clr_when_stalled pc %h aln %b exp 304/0", pc, align_err); end
    endtask

    task automatic test_random();
        logic [31:0] o;
        clr_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            o = $urandom & 32'h3FF;
            if ($urandom_range(0, 1) == 1) o = -o;
            drive(($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                  ($urandom % 8) == 0, ($urandom % 6) == 0,
                  $urandom & 32'h0000_FFFF, o, ($urandom % 16) == 0);
            n_cmp++; if (pc_next !== model_next()) begin n_err++; $display("FAIL rnd_pc_next cyc %0d got %h exp %h", i, pc_next, model_next()); end
            step();
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc, m_pc); end
            n_cmp++; if (ras_cnt !== 3'(m_stk.size())) begin n_err++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, ras_cnt, m_stk.size()); end
            n_cmp++; if ({ras_ovf, ras_unf, align_err} !== {m_ovf, m_unf, m_aln}) begin n_err++; $display("FAIL rnd_flags cyc %0d got %b exp %b", i, {ras_ovf, ras_unf, align_err}, {m_ovf, m_unf, m_aln}); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_priority();
        test_align();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
